// File: rtl/mac_tx_arbiter_pkg.sv
// Shared Ethernet TX definitions: arbiter states, requester channel IDs,
// EtherType constants and the payload length legality check.
package mac_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } arb_state_t;

  localparam logic CH_ARP = 1'b0;
  localparam logic CH_IP  = 1'b1;

  localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;

  localparam logic [7:0] PAD_BYTE = 8'h00;

  function automatic logic len_ok(input logic [15:0] len, input logic [15:0] max_len);
    return (len != 16'd0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/mac_tx_arbiter_rr_arb2.sv
// Two-way round-robin picker; the priority pointer moves past whichever
// channel was served so the other one wins the next contested pick.
module rr_arb2
  import mac_tx_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       pick,
  output logic       pick_valid
);

  logic prio_r;

  // Prefer the pointed-to channel, fall back to the other one.
  always_comb begin
    pick_valid = |req;
    if (req[prio_r]) begin
      pick = prio_r;
    end else begin
      pick = ~prio_r;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_r <= CH_ARP;
    end else if (advance) begin
      prio_r <= ~pick;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/mac_tx_arbiter.sv
// ARP/IP frame arbiter in front of the MAC transmitter: grants one requester,
// forwards exactly the announced length, pads short/stalled frames, counts errors.
module mac_tx_arbiter
  import mac_tx_arbiter_pkg::*;
#(
  parameter int P_TIMEOUT = 1024,
  parameter int P_MAX_LEN = 1500
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ch0_req,
  output logic        o_ch0_grant,
  input  logic [15:0] i_ch0_type,
  input  logic [15:0] i_ch0_len,
  input  logic [7:0]  i_ch0_data,
  input  logic        i_ch0_valid,
  input  logic        i_ch0_last,
  input  logic        i_ch1_req,
  output logic        o_ch1_grant,
  input  logic [15:0] i_ch1_type,
  input  logic [15:0] i_ch1_len,
  input  logic [7:0]  i_ch1_data,
  input  logic        i_ch1_valid,
  input  logic        i_ch1_last,
  output logic        o_mac_udp_valid,
  input  logic        i_mac_udp_ready,
  output logic [15:0] o_mac_type,
  output logic [15:0] o_mac_len,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_valid,
  output logic        o_mac_last,
  output logic        o_err,
  output logic [15:0] o_err_cnt
);

  localparam int TW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [15:0]   MAX_LEN = 16'(P_MAX_LEN);

  arb_state_t    state_r, state_s;
  logic [1:0]    grant_r, grant_s;
  logic          udp_valid_r, udp_valid_s;
  logic [15:0]   type_r, type_s, len_r, len_s;
  logic [15:0]   cnt_r, cnt_s, cnt_inc_s, err_cnt_r, err_cnt_s;
  logic [7:0]    data_r, data_s;
  logic          valid_r, valid_s, last_r, last_s, err_r, err_s;
  logic          ch_r, ch_s, pad_r, pad_s, hold_r, hold_s, ovr_r, ovr_s;
  logic [TW-1:0] idle_r, idle_s;
  logic          pick_s, pick_valid_s, adv_s;
  logic [15:0]   pick_len_s, pick_type_s;
  logic [7:0]    in_data_s;
  logic          in_valid_s, in_last_s;

  rr_arb2 u_rr_arb2 (
    .clk        (i_clk),
    .rst        (i_rst),
    .req        ({i_ch1_req, i_ch0_req}),
    .advance    (adv_s),
    .pick       (pick_s),
    .pick_valid (pick_valid_s)
  );

  assign cnt_inc_s = cnt_r + 16'd1;

  // Header fields of the pick candidate and payload of the granted channel.
  always_comb begin
    if (pick_s == CH_IP) begin
      pick_len_s  = i_ch1_len;
      pick_type_s = i_ch1_type;
    end else begin
      pick_len_s  = i_ch0_len;
      pick_type_s = i_ch0_type;
    end
    if (ch_r == CH_IP) begin
      in_data_s  = i_ch1_data;
      in_valid_s = i_ch1_valid;
      in_last_s  = i_ch1_last;
    end else begin
      in_data_s  = i_ch0_data;
      in_valid_s = i_ch0_valid;
      in_last_s  = i_ch0_last;
    end
  end

  // Next-state and next-output computation for every arbiter register.
  always_comb begin
    state_s     = state_r;
    grant_s     = 2'b00;
    udp_valid_s = 1'b0;
    type_s      = type_r;
    len_s       = len_r;
    data_s      = PAD_BYTE;
    valid_s     = 1'b0;
    last_s      = 1'b0;
    err_s       = 1'b0;
    ch_s        = ch_r;
    cnt_s       = cnt_r;
    idle_s      = idle_r;
    pad_s       = pad_r;
    hold_s      = hold_r;
    ovr_s       = ovr_r;
    adv_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // An outstanding grant pulse means the winner still holds its request this cycle.
        if (i_mac_udp_ready && pick_valid_s && (grant_r == 2'b00)) begin
          adv_s   = 1'b1;
          grant_s = (pick_s == CH_IP) ? 2'b10 : 2'b01;
          if (len_ok(pick_len_s, MAX_LEN)) begin
            state_s     = ST_GRANT;
            udp_valid_s = 1'b1;
            type_s      = pick_type_s;
            len_s       = pick_len_s;
            ch_s        = pick_s;
            cnt_s       = 16'd0;
            idle_s      = {TW{1'b0}};
            pad_s       = 1'b0;
            ovr_s       = 1'b0;
            hold_s      = 1'b0;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          adv_s = 1'b0;
        end
      end
      ST_GRANT: begin
        state_s = ST_XFER;
      end
      ST_XFER: begin
        if (pad_r) begin
          valid_s = 1'b1;
          cnt_s   = cnt_inc_s;
          if (cnt_inc_s == len_r) begin
            last_s  = 1'b1;
            pad_s   = 1'b0;
            state_s = ST_HOLD;
          end else begin
            pad_s = 1'b1;
          end
        end else if (in_valid_s) begin
          valid_s = 1'b1;
          data_s  = in_data_s;
          cnt_s   = cnt_inc_s;
          idle_s  = {TW{1'b0}};
          if (cnt_inc_s == len_r) begin
            last_s  = 1'b1;
            state_s = ST_HOLD;
          end else if (in_last_s) begin
            pad_s = 1'b1;
            err_s = 1'b1;
          end else begin
            pad_s = 1'b0;
          end
        end else if (idle_r == TO_LAST) begin
          pad_s = 1'b1;
          err_s = 1'b1;
        end else begin
          idle_s = idle_r + TW'(1);
        end
      end
      ST_HOLD: begin
        // Bytes beyond the announced length are dropped, flagged once per frame.
        if (in_valid_s && !ovr_r) begin
          err_s = 1'b1;
          ovr_s = 1'b1;
        end else begin
          ovr_s = ovr_r;
        end
        if (i_mac_udp_ready && hold_r) begin
          state_s = ST_IDLE;
          type_s  = 16'd0;
          len_s   = 16'd0;
        end else begin
          hold_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Saturating error counter.
  always_comb begin
    if (err_s && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_s = err_cnt_r + 16'd1;
    end else begin
      err_cnt_s = err_cnt_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      grant_r     <= 2'b00;
      udp_valid_r <= 1'b0;
      type_r      <= 16'd0;
      len_r       <= 16'd0;
      data_r      <= 8'd0;
      valid_r     <= 1'b0;
      last_r      <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= 16'd0;
      ch_r        <= CH_ARP;
      cnt_r       <= 16'd0;
      idle_r      <= {TW{1'b0}};
      pad_r       <= 1'b0;
      hold_r      <= 1'b0;
      ovr_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      grant_r     <= grant_s;
      udp_valid_r <= udp_valid_s;
      type_r      <= type_s;
      len_r       <= len_s;
      data_r      <= data_s;
      valid_r     <= valid_s;
      last_r      <= last_s;
      err_r       <= err_s;
      err_cnt_r   <= err_cnt_s;
      ch_r        <= ch_s;
      cnt_r       <= cnt_s;
      idle_r      <= idle_s;
      pad_r       <= pad_s;
      hold_r      <= hold_s;
      ovr_r       <= ovr_s;
    end
  end

  assign o_ch0_grant     = grant_r[0];
  assign o_ch1_grant     = grant_r[1];
  assign o_mac_udp_valid = udp_valid_r;
  assign o_mac_type      = type_r;
  assign o_mac_len       = len_r;
  assign o_mac_data      = data_r;
  assign o_mac_valid     = valid_r;
  assign o_mac_last      = last_r;
  assign o_err           = err_r;
  assign o_err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: normal frame, round-robin, padding, timeout,
// rejection, overrun, ready-low and mid-frame reset scenarios.
module tb_mac_tx_arbiter;
  import mac_tx_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [15:0] ch0_type = 16'd0, ch1_type = 16'd0, ch0_len = 16'd0, ch1_len = 16'd0;
  logic [7:0]  ch0_data = 8'd0, ch1_data = 8'd0;
  logic        ch0_valid = 1'b0, ch1_valid = 1'b0, ch0_last = 1'b0, ch1_last = 1'b0;
  logic        ch0_grant, ch1_grant, udp_valid, mac_ready, mac_valid, mac_last, err;
  logic [15:0] mac_type, mac_len, err_cnt;
  logic [7:0]  mac_data;

  int checks = 0;
  int failures = 0;
  logic [7:0]  byte_q[$];
  int          last_q[$];
  int          order_q[$];
  logic [31:0] hdr_q[$];
  int g0_cnt = 0, g1_cnt = 0, udp_cnt = 0, err_pulses = 0, busy_cnt = 0;
  logic mac_busy = 1'b0;
  logic ready_low = 1'b0;

  assign mac_ready = !mac_busy && !ready_low;

  mac_tx_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_ch0_req(ch0_req), .o_ch0_grant(ch0_grant), .i_ch0_type(ch0_type), .i_ch0_len(ch0_len),
    .i_ch0_data(ch0_data), .i_ch0_valid(ch0_valid), .i_ch0_last(ch0_last),
    .i_ch1_req(ch1_req), .o_ch1_grant(ch1_grant), .i_ch1_type(ch1_type), .i_ch1_len(ch1_len),
    .i_ch1_data(ch1_data), .i_ch1_valid(ch1_valid), .i_ch1_last(ch1_last),
    .o_mac_udp_valid(udp_valid), .i_mac_udp_ready(mac_ready),
    .o_mac_type(mac_type), .o_mac_len(mac_len), .o_mac_data(mac_data),
    .o_mac_valid(mac_valid), .o_mac_last(mac_last), .o_err(err), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // MAC-side monitor and simple transmitter model: busy from frame start until shortly after last.
  always @(negedge clk) begin
    if (rst) begin
      mac_busy <= 1'b0;
      busy_cnt <= 0;
    end else begin
      if (udp_valid) begin
        udp_cnt <= udp_cnt + 1;
        order_q.push_back(ch1_grant ? 1 : 0);
        hdr_q.push_back({mac_type, mac_len});
        mac_busy <= 1'b1;
      end
      if (ch0_grant) g0_cnt <= g0_cnt + 1;
      if (ch1_grant) g1_cnt <= g1_cnt + 1;
      if (err) err_pulses <= err_pulses + 1;
      if (mac_valid) begin
        byte_q.push_back(mac_data);
        if (mac_last) last_q.push_back(byte_q.size());
      end
      if (mac_valid && mac_last) begin
        busy_cnt <= 3;
      end else if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) mac_busy <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] pat(input int ch, input int i);
    return 8'(64 + (i % 64) + (ch * 128));
  endfunction

  function automatic logic [63:0] all_outs();
    return {2'b00, ch0_grant, ch1_grant, udp_valid, mac_type, mac_len, mac_data,
            mac_valid, mac_last, err, err_cnt};
  endfunction

  task automatic set_req(input int ch, input logic r, input logic [15:0] t, input logic [15:0] l);
    if (ch == 0) begin ch0_req = r; ch0_type = t; ch0_len = l; end
    else begin ch1_req = r; ch1_type = t; ch1_len = l; end
  endtask

  task automatic set_byte(input int ch, input logic v, input logic [7:0] d, input logic l);
    if (ch == 0) begin ch0_valid = v; ch0_data = d; ch0_last = l; end
    else begin ch1_valid = v; ch1_data = d; ch1_last = l; end
  endtask

  // Requester model: hold request until granted, then stream nbytes starting once in XFER.
  task automatic send(input int ch, input logic [15:0] typ, input logic [15:0] len,
                      input int nbytes, input bit with_last);
    bit got = 1'b0;
    set_req(ch, 1'b1, typ, len);
    for (int k = 0; k < 4000 && !got; k++) begin
      tick();
      got = (ch == 0) ? ch0_grant : ch1_grant;
    end
    set_req(ch, 1'b0, typ, len);
    check_eq($sformatf("grant_seen_ch%0d", ch), 64'(got), 64'd1);
    if (got) begin
      tick();
      for (int i = 0; i < nbytes; i++) begin
        set_byte(ch, 1'b1, pat(ch, i), with_last && (i == nbytes - 1));
        tick();
      end
      set_byte(ch, 1'b0, 8'h00, 1'b0);
    end
  endtask

  task automatic wait_bytes(input string tag, input int target, input int budget);
    for (int k = 0; k < budget && byte_q.size() < target; k++) tick();
    check_eq({tag, "_done"}, 64'(byte_q.size() >= target), 64'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input int ch, input int len, input int nsent);
    int mism = 0;
    int nl = 0;
    int pos = 0;
    logic [7:0] e;
    for (int i = 0; i < len; i++) begin
      e = (i < nsent) ? pat(ch, i) : 8'h00;
      if ((base + i >= byte_q.size()) || (byte_q[base + i] != e)) mism++;
    end
    foreach (last_q[j]) begin
      if (last_q[j] > base && last_q[j] <= base + len) begin
        nl++;
        pos = last_q[j];
      end
    end
    check_eq({tag, "_data"}, 64'(mism), 64'd0);
    check_eq({tag, "_last_n"}, 64'(nl), 64'd1);
    check_eq({tag, "_last_pos"}, 64'(pos - base), 64'(len));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready_low = 1'b0;
    set_req(0, 1'b0, 16'd0, 16'd0);
    set_req(1, 1'b0, 16'd0, 16'd0);
    set_byte(0, 1'b0, 8'd0, 1'b0);
    set_byte(1, 1'b0, 8'd0, 1'b0);
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, ord, e0, gb, ub;
    ticks(2);
    check_eq("reset_outs", all_outs(), 64'd0);
    rst = 1'b0;
    tick();

    // Both requesters at once after reset: ch0 first, then ch1; repeats the same way.
    for (int r = 0; r < 2; r++) begin
      base = byte_q.size();
      ord  = order_q.size();
      fork
        send(0, ETH_TYPE_ARP, 16'd64, 64, 1'b1);
        send(1, ETH_TYPE_IP, 16'd64, 64, 1'b1);
      join
      wait_bytes($sformatf("rr%0d", r), base + 128, 400);
      check_eq($sformatf("rr%0d_frames", r), 64'(order_q.size() - ord), 64'd2);
      check_eq($sformatf("rr%0d_first", r), 64'(order_q[ord]), 64'd0);
      check_eq($sformatf("rr%0d_second", r), 64'(order_q[ord + 1]), 64'd1);
      check_eq($sformatf("rr%0d_hdr0", r), 64'(hdr_q[ord]), 64'h0806_0040);
      check_eq($sformatf("rr%0d_hdr1", r), 64'(hdr_q[ord + 1]), 64'h0800_0040);
      check_frame($sformatf("rr%0d_ch0", r), base, 0, 64, 64);
      check_frame($sformatf("rr%0d_ch1", r), base + 64, 1, 64, 64);
    end

    // Single ARP frame, 28 contiguous bytes.
    base = byte_q.size();
    ub = udp_cnt;
    ord = order_q.size();
    send(0, ETH_TYPE_ARP, 16'd28, 28, 1'b1);
    wait_bytes("arp28", base + 28, 50);
    ticks(2);
    check_frame("arp28", base, 0, 28, 28);
    check_eq("arp28_udp", 64'(udp_cnt - ub), 64'd1);
    check_eq("arp28_hdr", 64'(hdr_q[ord]), 64'h0806_001c);
    check_eq("arp28_bytes", 64'(byte_q.size() - base), 64'd28);
    check_eq("arp28_errcnt", 64'(err_cnt), 64'd0);

    // ch0 was served last, so a contested pick now goes to ch1.
    base = byte_q.size();
    ord = order_q.size();
    fork
      send(0, ETH_TYPE_ARP, 16'd5, 5, 1'b1);
      send(1, ETH_TYPE_IP, 16'd5, 5, 1'b1);
    join
    wait_bytes("ptr", base + 10, 100);
    check_eq("ptr_first", 64'(order_q[ord]), 64'd1);
    check_frame("ptr_ch1", base, 1, 5, 5);
    check_frame("ptr_ch0", base + 5, 0, 5, 5);

    // Largest legal length is accepted.
    base = byte_q.size();
    send(0, ETH_TYPE_IP, 16'd1500, 1500, 1'b1);
    wait_bytes("max", base + 1500, 50);
    check_frame("max", base, 0, 1500, 1500);

    // Early last on ch1: 6 real bytes then 4 pad bytes.
    do_reset();
    base = byte_q.size();
    send(1, ETH_TYPE_IP, 16'd10, 6, 1'b1);
    wait_bytes("pad", base + 10, 50);
    ticks(2);
    check_frame("pad", base, 1, 10, 6);
    check_eq("pad_errcnt", 64'(err_cnt), 64'd1);

    // Stall after 3 bytes: nothing happens before the timeout, then 5 pad bytes.
    do_reset();
    base = byte_q.size();
    e0 = err_pulses;
    send(0, ETH_TYPE_ARP, 16'd8, 3, 1'b0);
    ticks(1000);
    check_eq("to_early_bytes", 64'(byte_q.size() - base), 64'd3);
    check_eq("to_early_err", 64'(err_pulses - e0), 64'd0);
    wait_bytes("to", base + 8, 80);
    ticks(2);
    check_frame("to", base, 0, 8, 3);
    check_eq("to_err_pulses", 64'(err_pulses - e0), 64'd1);
    check_eq("to_errcnt", 64'(err_cnt), 64'd1);
    base = byte_q.size();
    send(1, ETH_TYPE_IP, 16'd2, 2, 1'b1);
    wait_bytes("to_next", base + 2, 50);
    check_frame("to_next", base, 1, 2, 2);

    // Illegal lengths 0 and 1501: grant pulses and errors, no MAC frame.
    do_reset();
    base = byte_q.size();
    gb = g1_cnt;
    ub = udp_cnt;
    send(1, ETH_TYPE_IP, 16'd0, 0, 1'b0);
    send(1, ETH_TYPE_IP, 16'd1501, 0, 1'b0);
    ticks(4);
    check_eq("rej_grants", 64'(g1_cnt - gb), 64'd2);
    check_eq("rej_udp", 64'(udp_cnt - ub), 64'd0);
    check_eq("rej_bytes", 64'(byte_q.size() - base), 64'd0);
    check_eq("rej_errcnt", 64'(err_cnt), 64'd2);

    // Requester keeps sending past the length: extras dropped, one error.
    do_reset();
    base = byte_q.size();
    e0 = err_pulses;
    send(0, ETH_TYPE_ARP, 16'd4, 6, 1'b1);
    ticks(6);
    check_frame("ovr", base, 0, 4, 4);
    check_eq("ovr_bytes", 64'(byte_q.size() - base), 64'd4);
    check_eq("ovr_err_pulses", 64'(err_pulses - e0), 64'd1);

    // Request while the MAC is not ready: no grant until ready returns.
    do_reset();
    gb = g0_cnt;
    ready_low = 1'b1;
    set_req(0, 1'b1, ETH_TYPE_ARP, 16'd8);
    ticks(5);
    check_eq("notready_grant", 64'(g0_cnt - gb), 64'd0);
    ready_low = 1'b0;
    base = byte_q.size();
    send(0, ETH_TYPE_ARP, 16'd8, 8, 1'b1);
    wait_bytes("notready", base + 8, 50);
    check_frame("notready", base, 0, 8, 8);

    // Reset in the middle of a 64-byte frame, then a clean restart.
    do_reset();
    base = byte_q.size();
    fork
      send(0, ETH_TYPE_ARP, 16'd64, 64, 1'b1);
      begin
        for (int k = 0; k < 300 && byte_q.size() < base + 20; k++) tick();
        rst = 1'b1;
        #1;
        check_eq("rst_mid_outs", all_outs(), 64'd0);
        ticks(2);
        rst = 1'b0;
      end
    join
    ticks(3);
    check_eq("rst_mid_bytes", 64'(byte_q.size() - base), 64'd20);
    base = byte_q.size();
    ub = udp_cnt;
    send(0, ETH_TYPE_ARP, 16'd28, 28, 1'b1);
    wait_bytes("restart", base + 28, 50);
    check_frame("restart", base, 0, 28, 28);
    check_eq("restart_udp", 64'(udp_cnt - ub), 64'd1);
    check_eq("restart_errcnt", 64'(err_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
